// File: rtl/dram_pkg.sv
// Shared command codes, FSM state encoding and small elaboration helpers
// for the DRAM command responder.
package dram_pkg;

  typedef enum logic [1:0] {
    CMD_ACT = 2'b00,
    CMD_RD  = 2'b01,
    CMD_WR  = 2'b10,
    CMD_PRE = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ACK  = 2'b10
  } state_e;

  // Index width for a one-hot vector; never narrower than one bit.
  function automatic int idx_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/dram_onehot_enc.sv
// One-hot to binary encoder. The index reports the lowest set bit (0 when
// the vector is empty); o_one_hot_ok is set only when exactly one bit is set.
module dram_onehot_enc
  import dram_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]        i_vec,
  output logic [idx_w(WIDTH)-1:0] o_idx,
  output logic                    o_one_hot_ok
);

  localparam int IW = idx_w(WIDTH);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    o_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IW'(i);
    end
  end

  // Power-of-two test: non-zero with no second bit set.
  always_comb begin
    o_one_hot_ok = (i_vec != '0) && ((i_vec & (i_vec - WIDTH'(1))) == '0);
  end

endmodule

// File: rtl/dram_cmd_responder.sv
// Device-side responder for the four-phase cmd_req/cmd_ack handshake.
// Latches a command, waits its timing latency, acknowledges, tracks the
// open row per bank and flags protocol/timing-rule violations.
module dram_cmd_responder
  import dram_pkg::*;
#(
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int T_RCD        = 3,
  parameter int T_CAS        = 2,
  parameter int T_WR         = 2,
  parameter int T_RP         = 3
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_cmd_req,
  input  logic [1:0]                       i_cmd,
  input  logic [NUM_OF_BANKS-1:0]          i_bank_sel,
  input  logic [NUM_OF_ROWS-1:0]           i_row_sel,
  input  logic [NUM_OF_COLS-1:0]           i_col_sel,
  output logic                             o_cmd_ack,
  output logic                             o_cmd_err,
  output logic [idx_w(NUM_OF_BANKS)-1:0]   o_bank_id,
  output logic [idx_w(NUM_OF_ROWS)-1:0]    o_row_id,
  output logic [idx_w(NUM_OF_COLS)-1:0]    o_col_id,
  output logic                             o_bank_rw,
  output logic [NUM_OF_BANKS-1:0]          o_bank_open,
  output logic                             o_busy
);

  localparam int BW   = idx_w(NUM_OF_BANKS);
  localparam int RW   = idx_w(NUM_OF_ROWS);
  localparam int CLW  = idx_w(NUM_OF_COLS);
  localparam int TMAX = max4(T_RCD, T_CAS, T_WR, T_RP);
  localparam int CNTW = $clog2(TMAX) + 1;

  logic [BW-1:0]   w_bank_idx;
  logic [RW-1:0]   w_row_idx;
  logic [CLW-1:0]  w_col_idx;
  logic            w_bank_ok, w_row_ok, w_col_ok;
  logic            w_sel_ok;
  logic [CNTW-1:0] w_lat;
  logic            w_open_cur;
  logic            w_err;

  state_e                       r_state;
  cmd_e                         r_cmd;
  logic [CNTW-1:0]              r_cnt;
  logic                         r_sel_ok;
  logic                         r_cmd_ack;
  logic                         r_cmd_err;
  logic [BW-1:0]                r_bank_id;
  logic [RW-1:0]                r_row_id;
  logic [CLW-1:0]               r_col_id;
  logic                         r_bank_rw;
  logic                         r_busy;
  logic [NUM_OF_BANKS-1:0]      r_bank_open;
  logic [NUM_OF_BANKS-1:0][RW-1:0] r_open_row;

  dram_onehot_enc #(.WIDTH(NUM_OF_BANKS)) u_bank_enc (
    .i_vec(i_bank_sel), .o_idx(w_bank_idx), .o_one_hot_ok(w_bank_ok));
  dram_onehot_enc #(.WIDTH(NUM_OF_ROWS)) u_row_enc (
    .i_vec(i_row_sel), .o_idx(w_row_idx), .o_one_hot_ok(w_row_ok));
  dram_onehot_enc #(.WIDTH(NUM_OF_COLS)) u_col_enc (
    .i_vec(i_col_sel), .o_idx(w_col_idx), .o_one_hot_ok(w_col_ok));

  // Select legality and latency for the incoming command; only the selects
  // the command actually uses take part in the one-hot check.
  always_comb begin
    w_sel_ok = w_bank_ok;
    w_lat    = CNTW'(T_RP - 1);
    case (i_cmd)
      CMD_ACT: begin w_sel_ok = w_bank_ok & w_row_ok; w_lat = CNTW'(T_RCD - 1); end
      CMD_RD:  begin w_sel_ok = w_bank_ok & w_col_ok; w_lat = CNTW'(T_CAS - 1); end
      CMD_WR:  begin w_sel_ok = w_bank_ok & w_col_ok; w_lat = CNTW'(T_WR - 1);  end
      default: begin w_sel_ok = w_bank_ok;            w_lat = CNTW'(T_RP - 1);  end
    endcase
  end

  // Rule check on the latched command; bank state cannot move during WAIT,
  // so evaluating it at the ack edge sees the same state as at latch time.
  always_comb begin
    w_open_cur = r_bank_open[r_bank_id];
    w_err      = !r_sel_ok
               || ((r_cmd == CMD_ACT) && w_open_cur)
               || (((r_cmd == CMD_RD) || (r_cmd == CMD_WR)) && !w_open_cur);
  end

  // Handshake FSM: latch, count down the latency, ack, wait for req release.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cmd       <= CMD_ACT;
      r_cnt       <= '0;
      r_sel_ok    <= 1'b0;
      r_cmd_ack   <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_bank_id   <= '0;
      r_row_id    <= '0;
      r_col_id    <= '0;
      r_bank_rw   <= 1'b0;
      r_busy      <= 1'b0;
      r_bank_open <= '0;
      r_open_row  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_cmd_req) begin
            r_cmd     <= cmd_e'(i_cmd);
            r_bank_id <= w_bank_idx;
            // RD/WR/PRE report the row currently recorded for the bank.
            r_row_id  <= (i_cmd == CMD_ACT) ? w_row_idx : r_open_row[w_bank_idx];
            r_col_id  <= w_col_idx;
            r_bank_rw <= (i_cmd == CMD_WR);
            r_sel_ok  <= w_sel_ok;
            r_cnt     <= w_lat;
            r_busy    <= 1'b1;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_cmd_ack <= 1'b1;
            r_cmd_err <= w_err;
            if (!w_err) begin
              case (r_cmd)
                CMD_ACT: begin
                  r_bank_open[r_bank_id] <= 1'b1;
                  r_open_row[r_bank_id]  <= r_row_id;
                end
                CMD_PRE: r_bank_open[r_bank_id] <= 1'b0;
                default: ;
              endcase
            end
            r_state <= ACK;
          end else begin
            r_cnt <= r_cnt - CNTW'(1);
          end
        end
        ACK: begin
          if (!i_cmd_req) begin
            r_cmd_ack <= 1'b0;
            r_cmd_err <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_cmd_ack   = r_cmd_ack;
  assign o_cmd_err   = r_cmd_err;
  assign o_bank_id   = r_bank_id;
  assign o_row_id    = r_row_id;
  assign o_col_id    = r_col_id;
  assign o_bank_rw   = r_bank_rw;
  assign o_bank_open = r_bank_open;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_dram_cmd_responder.sv
// Bench for dram_cmd_responder: directed handshake scenarios followed by
// randomized commands, checked against a per-bank open/row model.
module tb_dram_cmd_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_req = 1'b0;
  logic [1:0]   cmd = 2'b00;
  logic [7:0]   bank_sel = '0;
  logic [127:0] row_sel = '0;
  logic [7:0]   col_sel = '0;
  logic         cmd_ack, cmd_err, bank_rw, busy;
  logic [2:0]   bank_id;
  logic [6:0]   row_id;
  logic [2:0]   col_id;
  logic [7:0]   bank_open;

  int tests = 0;
  int fails = 0;

  // Reference model: which banks are open and the last row activated in each.
  bit m_open[8];
  int m_row[8];

  always #5 clk = ~clk;

  dram_cmd_responder dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_req(cmd_req), .i_cmd(cmd),
    .i_bank_sel(bank_sel), .i_row_sel(row_sel), .i_col_sel(col_sel),
    .o_cmd_ack(cmd_ack), .o_cmd_err(cmd_err), .o_bank_id(bank_id),
    .o_row_id(row_id), .o_col_id(col_id), .o_bank_rw(bank_rw),
    .o_bank_open(bank_open), .o_busy(busy));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int low_idx(input logic [127:0] v, input int w);
    for (int i = 0; i < w; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [7:0] model_open_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_open[i];
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin m_open[i] = 0; m_row[i] = 0; end
  endfunction

  // Issue one command starting just after a rising edge; check latency,
  // reported fields, bank state, hold behaviour and release.
  task automatic run_cmd(input logic [1:0] c, input logic [7:0] b, input logic [127:0] r,
                         input logic [7:0] cs, input int hold, input bit glitch,
                         input string tag);
    int bi, ri, ci, lat, n, exp_row;
    bit ok, err;
    bi  = low_idx({120'b0, b}, 8);
    ri  = low_idx(r, 128);
    ci  = low_idx({120'b0, cs}, 8);
    ok  = ($countones(b) == 1);
    if (c == 2'b00) ok = ok && ($countones(r) == 1);
    if (c == 2'b01 || c == 2'b10) ok = ok && ($countones(cs) == 1);
    err = !ok || (c == 2'b00 && m_open[bi]) || ((c == 2'b01 || c == 2'b10) && !m_open[bi]);
    lat = (c == 2'b00 || c == 2'b11) ? 3 : 2;
    exp_row = (c == 2'b00) ? ri : m_row[bi];

    cmd = c; bank_sel = b; row_sel = r; col_sel = cs; cmd_req = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".busy_start"}, busy, 1'b1);
    if (glitch) begin bank_sel = 8'h00; cmd = ~c; col_sel = 8'h00; end
    n = 0;
    while (cmd_ack !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk({tag, ".latency"}, n, lat);
    chk({tag, ".err"}, cmd_err, err);
    chk({tag, ".bank_id"}, bank_id, bi);
    chk({tag, ".row_id"}, row_id, exp_row);
    chk({tag, ".col_id"}, col_id, ci);
    chk({tag, ".bank_rw"}, bank_rw, (c == 2'b10));
    if (!err) begin
      if (c == 2'b00) begin m_open[bi] = 1; m_row[bi] = ri; end
      if (c == 2'b11) m_open[bi] = 0;
    end
    chk({tag, ".bank_open"}, bank_open, model_open_vec());
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, ".ack_hold"}, cmd_ack, 1'b1);
    end
    cmd_req = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".ack_drop"}, cmd_ack, 1'b0);
    chk({tag, ".busy_end"}, busy, 1'b0);
    chk({tag, ".err_clr"}, cmd_err, 1'b0);
  endtask

  initial begin
    logic [1:0]   rc;
    logic [7:0]   rb, rcol;
    logic [127:0] rr;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("reset.ack", cmd_ack, 1'b0);
    chk("reset.busy", busy, 1'b0);
    chk("reset.err", cmd_err, 1'b0);
    chk("reset.bank_open", bank_open, 8'h00);
    chk("reset.ids", {bank_id, row_id, col_id, bank_rw}, 14'h0);

    // Open bank 1, then abort an ACT on bank 3 with an asynchronous reset.
    run_cmd(2'b00, 8'h02, 128'h200, 8'h01, 0, 0, "act_b1");
    cmd = 2'b00; bank_sel = 8'h08; row_sel = 128'h20; col_sel = 8'h01; cmd_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_mid.ack", cmd_ack, 1'b0);
    chk("rst_mid.busy", busy, 1'b0);
    chk("rst_mid.bank_open", bank_open, 8'h00);
    cmd_req = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #1;

    run_cmd(2'b00, 8'h08, 128'h20, 8'h01, 0, 0, "act_b3_r5");
    chk("act_b3_r5.open_exact", bank_open, 8'h08);
    run_cmd(2'b01, 8'h08, 128'h0, 8'h10, 0, 0, "rd_b3");
    run_cmd(2'b10, 8'h08, 128'h0, 8'h10, 0, 0, "wr_b3");
    run_cmd(2'b01, 8'h04, 128'h0, 8'h10, 0, 0, "rd_closed_b2");
    run_cmd(2'b00, 8'h08, 128'h40, 8'h01, 0, 0, "act_b3_again");
    run_cmd(2'b11, 8'h08, 128'h0, 8'h01, 0, 0, "pre_b3");
    chk("pre_b3.open_exact", bank_open, 8'h00);
    run_cmd(2'b11, 8'h08, 128'h0, 8'h01, 0, 0, "pre_closed");
    run_cmd(2'b00, 8'h40, 128'h1 << 20, 8'h01, 10, 0, "act_hold10");
    run_cmd(2'b00, 8'h10, 128'h1 << 77, 8'h02, 1, 1, "act_glitch");
    run_cmd(2'b00, 8'h00, 128'h1, 8'h01, 0, 0, "act_nobank");
    run_cmd(2'b01, 8'h40, 128'h0, 8'h03, 0, 0, "rd_badcol");

    for (int k = 0; k < 60; k++) begin
      rc = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) rb = 8'($urandom_range(0, 255));
      else rb = 8'h01 << $urandom_range(0, 7);
      rr = '0;
      if ($urandom_range(0, 9) == 0) rr = {$urandom, $urandom, $urandom, $urandom};
      else rr[$urandom_range(0, 127)] = 1'b1;
      if ($urandom_range(0, 9) == 0) rcol = 8'($urandom_range(0, 255));
      else rcol = 8'h01 << $urandom_range(0, 7);
      run_cmd(rc, rb, rr, rcol, $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
